assert_monitor: RTL and testbench

Synthesizable, parametrised multi-channel immediate-assertion checker. Each clock it samples NCH signal pairs (a, b), evaluates a per-block check mode, and keeps per-channel pass/fail counters, sticky fail flags, a first-failure record with cycle timestamp, and a threshold alarm. It replaces ad-hoc `assert (a&&b)` plus `$display` checks in benches. It also lives in RTL as a debug/self-check block whose results are read out by software or a bench.

---
 rtl/assert_monitor.sv | 135 +++++++++++++
 tb/tb_assert_monitor.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/assert_monitor.sv
// Multi-channel immediate-assertion checker: per-channel pass/fail counters, sticky flags,
// a timestamped first-failure record, and a saturating total-fail alarm.
module assert_monitor #(
    parameter  int NCH   = 4,
    parameter  int CNT_W = 16,
    parameter  int TS_W  = 32,
    parameter  int MODE  = 0,
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 clr,
    input  logic [NCH-1:0]       a,
    input  logic [NCH-1:0]       b,
    input  logic [NCH-1:0]       chk_mask,
    input  logic [CNT_W-1:0]     fail_thresh,
    output logic [NCH*CNT_W-1:0] pass_cnt,
    output logic [NCH*CNT_W-1:0] fail_cnt,
    output logic [NCH-1:0]       fail_sticky,
    output logic                 first_fail_vld,
    output logic [CH_W-1:0]      first_fail_ch,
    output logic [TS_W-1:0]      first_fail_ts,
    output logic [CNT_W-1:0]     total_fail,
    output logic                 alarm
);
    localparam int SUM_W = CNT_W + 6;
    localparam logic [SUM_W-1:0] SAT = {6'd0, {CNT_W{1'b1}}};

    typedef enum logic [1:0] {IDLE, ARMED, TRIPPED} state_t;

    state_t           state;
    logic [TS_W-1:0]  ts;
    logic [NCH-1:0]   pass_ev;
    logic [NCH-1:0]   fail_ev;
    logic [5:0]       n_fail;
    logic [SUM_W-1:0] total_sum;
    logic [CNT_W-1:0] total_next;
    logic [CH_W-1:0]  low_ch;
    logic             trip;

    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        pass_ev = '0;
        fail_ev = '0;
        n_fail  = '0;
        low_ch  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (en && chk_mask[i]) begin
                case (MODE)
                    0: begin
                        pass_ev[i] = a[i] & b[i];
                        fail_ev[i] = ~(a[i] & b[i]);
                    end
                    1: begin
                        // a=0 is vacuous: neither pass nor fail.
                        pass_ev[i] = a[i] & b[i];
                        fail_ev[i] = a[i] & ~b[i];
                    end
                    default: begin
                        pass_ev[i] = ~(a[i] ^ b[i]);
                        fail_ev[i] = a[i] ^ b[i];
                    end
                endcase
            end
        end
        for (int i = NCH - 1; i >= 0; i--) begin
            n_fail = n_fail + 6'(fail_ev[i]);
            if (fail_ev[i]) low_ch = CH_W'(i);
        end
        total_sum  = SUM_W'(total_fail) + SUM_W'(n_fail);
        total_next = (total_sum > SAT) ? {CNT_W{1'b1}} : total_sum[CNT_W-1:0];
        trip       = en && (fail_thresh != '0) && (total_next >= fail_thresh);
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous
    // and clears every counter so the readout is always defined.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts             <= '0;
            state          <= IDLE;
            alarm          <= 1'b0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            fail_sticky    <= '0;
            first_fail_vld <= 1'b0;
            first_fail_ch  <= '0;
            first_fail_ts  <= '0;
            total_fail     <= '0;
        end else begin
            ts <= ts + TS_W'(1);
            if (clr) begin
                state          <= IDLE;
                alarm          <= 1'b0;
                pass_cnt       <= '0;
                fail_cnt       <= '0;
                fail_sticky    <= '0;
                first_fail_vld <= 1'b0;
                first_fail_ch  <= '0;
                first_fail_ts  <= '0;
                total_fail     <= '0;
            end else begin
                for (int i = 0; i < NCH; i++) begin
                    if (pass_ev[i] && !(&pass_cnt[i*CNT_W +: CNT_W]))
                        pass_cnt[i*CNT_W +: CNT_W] <= pass_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
                    if (fail_ev[i] && !(&fail_cnt[i*CNT_W +: CNT_W]))
                        fail_cnt[i*CNT_W +: CNT_W] <= fail_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
                end
                fail_sticky <= fail_sticky | fail_ev;
                total_fail  <= total_next;
                if (!first_fail_vld && (|fail_ev)) begin
                    first_fail_vld <= 1'b1;
                    first_fail_ch  <= low_ch;
                    first_fail_ts  <= ts;
                end
                // An enabled sample from IDLE arms and may trip on the same edge.
                case (state)
                    TRIPPED: begin
                        state <= TRIPPED;
                        alarm <= 1'b1;
                    end
                    default: begin
                        if (trip) begin
                            state <= TRIPPED;
                            alarm <= 1'b1;
                        end else begin
                            state <= en ? ARMED : IDLE;
                            alarm <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_assert_monitor.sv
// Directed bench for assert_monitor: a vector table for AND mode plus hand-written
// sequences for IMPLY/EQUAL, threshold alarm, saturation, clr collisions and reset.
module tb_assert_monitor;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0, clr = 1'b0;
    logic [3:0]  a = '0, b = '0, mask = '0;
    logic [15:0] thresh = '0;
    logic [3:0]  thresh4 = '0;

    logic [63:0] and_pass, and_fail, imp_pass, imp_fail, eq_pass, eq_fail;
    logic [15:0] sat_pass, sat_fail;
    logic [3:0]  and_sticky, imp_sticky, eq_sticky, sat_sticky;
    logic        and_ffv, imp_ffv, eq_ffv, sat_ffv;
    logic [1:0]  and_ffch, imp_ffch, eq_ffch, sat_ffch;
    logic [31:0] and_ffts, imp_ffts, eq_ffts, sat_ffts;
    logic [15:0] and_total, imp_total, eq_total;
    logic [3:0]  sat_total;
    logic        and_alarm, imp_alarm, eq_alarm, sat_alarm;

    int n_tests = 0;
    int n_fail  = 0;
    int ts_m    = 0;

    always #5 clk = ~clk;

    assert_monitor #(.NCH(4), .CNT_W(16), .TS_W(32), .MODE(0)) u_and (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b), .chk_mask(mask),
        .fail_thresh(thresh), .pass_cnt(and_pass), .fail_cnt(and_fail),
        .fail_sticky(and_sticky), .first_fail_vld(and_ffv), .first_fail_ch(and_ffch),
        .first_fail_ts(and_ffts), .total_fail(and_total), .alarm(and_alarm));

    assert_monitor #(.NCH(4), .CNT_W(16), .TS_W(32), .MODE(1)) u_imp (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b), .chk_mask(mask),
        .fail_thresh(thresh), .pass_cnt(imp_pass), .fail_cnt(imp_fail),
        .fail_sticky(imp_sticky), .first_fail_vld(imp_ffv), .first_fail_ch(imp_ffch),
        .first_fail_ts(imp_ffts), .total_fail(imp_total), .alarm(imp_alarm));

    assert_monitor #(.NCH(4), .CNT_W(16), .TS_W(32), .MODE(2)) u_eq (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b), .chk_mask(mask),
        .fail_thresh(thresh), .pass_cnt(eq_pass), .fail_cnt(eq_fail),
        .fail_sticky(eq_sticky), .first_fail_vld(eq_ffv), .first_fail_ch(eq_ffch),
        .first_fail_ts(eq_ffts), .total_fail(eq_total), .alarm(eq_alarm));

    assert_monitor #(.NCH(4), .CNT_W(4), .TS_W(32), .MODE(0)) u_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b), .chk_mask(mask),
        .fail_thresh(thresh4), .pass_cnt(sat_pass), .fail_cnt(sat_fail),
        .fail_sticky(sat_sticky), .first_fail_vld(sat_ffv), .first_fail_ch(sat_ffch),
        .first_fail_ts(sat_ffts), .total_fail(sat_total), .alarm(sat_alarm));

    typedef struct {
        logic        en, clr;
        logic [3:0]  a, b, mask;
        logic [63:0] pass, fail;
        logic [3:0]  sticky;
        logic [15:0] total;
        logic        ffv;
        logic [1:0]  ffch;
        logic [31:0] ffts;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [63:0] c4(input int c0, input int c1, input int c2, input int c3);
        return {c3[15:0], c2[15:0], c1[15:0], c0[15:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ts_m mirrors the value the timestamp holds during the cycle after each edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!rst_n) ts_m = 0;
        else        ts_m++;
    endtask

    task automatic check_and_zero(input string tag);
        check({tag, " pass"},   and_pass,   '0);
        check({tag, " fail"},   and_fail,   '0);
        check({tag, " sticky"}, 64'(and_sticky), '0);
        check({tag, " ffv"},    64'(and_ffv),    '0);
        check({tag, " ffch"},   64'(and_ffch),   '0);
        check({tag, " ffts"},   64'(and_ffts),   '0);
        check({tag, " total"},  64'(and_total),  '0);
        check({tag, " alarm"},  64'(and_alarm),  '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] bseq [5];
        int eq_ts, imp_ts;
        bseq = '{4'hF, 4'h0, 4'hA, 4'h5, 4'h3};

        vecs[0] = '{1, 0, 4'hF, 4'hF, 4'hF, c4(1,1,1,1), c4(0,0,0,0), 4'h0, 0, 0, 0, 0};
        vecs[1] = '{1, 0, 4'hF, 4'hF, 4'hF, c4(2,2,2,2), c4(0,0,0,0), 4'h0, 0, 0, 0, 0};
        vecs[2] = '{1, 0, 4'hF, 4'hF, 4'hF, c4(3,3,3,3), c4(0,0,0,0), 4'h0, 0, 0, 0, 0};
        vecs[3] = '{1, 0, 4'h5, 4'hF, 4'hF, c4(4,3,4,3), c4(0,1,0,1), 4'hA, 2, 1, 1, 3};
        vecs[4] = '{0, 0, 4'h0, 4'h0, 4'hF, c4(4,3,4,3), c4(0,1,0,1), 4'hA, 2, 1, 1, 3};
        vecs[5] = '{1, 0, 4'h0, 4'hF, 4'h1, c4(4,3,4,3), c4(1,1,0,1), 4'hB, 3, 1, 1, 3};
        vecs[6] = '{1, 0, 4'hF, 4'h3, 4'hC, c4(4,3,4,3), c4(1,1,1,2), 4'hF, 5, 1, 1, 3};
        vecs[7] = '{1, 1, 4'h0, 4'h0, 4'hF, c4(0,0,0,0), c4(0,0,0,0), 4'h0, 0, 0, 0, 0};
        vecs[8] = '{1, 0, 4'hE, 4'hF, 4'hF, c4(0,1,1,1), c4(1,0,0,0), 4'h1, 1, 1, 0, 8};

        tick();
        tick();
        check_and_zero("reset");
        check("reset sat total", 64'(sat_total), '0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            en = vecs[i].en; clr = vecs[i].clr;
            a = vecs[i].a; b = vecs[i].b; mask = vecs[i].mask;
            tick();
            check($sformatf("v%0d pass", i),   and_pass,         vecs[i].pass);
            check($sformatf("v%0d fail", i),   and_fail,         vecs[i].fail);
            check($sformatf("v%0d sticky", i), 64'(and_sticky),  64'(vecs[i].sticky));
            check($sformatf("v%0d total", i),  64'(and_total),   64'(vecs[i].total));
            check($sformatf("v%0d ffv", i),    64'(and_ffv),     64'(vecs[i].ffv));
            check($sformatf("v%0d ffch", i),   64'(and_ffch),    64'(vecs[i].ffch));
            check($sformatf("v%0d ffts", i),   64'(and_ffts),    64'(vecs[i].ffts));
            check($sformatf("v%0d alarm", i),  64'(and_alarm),   '0);
        end

        // IMPLY vacuity and EQUAL on the same stimulus.
        en = 0; clr = 1; tick(); clr = 0;
        en = 1; mask = 4'hF; a = 4'h0;
        eq_ts = ts_m;
        for (int i = 0; i < 5; i++) begin
            b = bseq[i];
            tick();
        end
        check("imp vacuous pass",  imp_pass, '0);
        check("imp vacuous fail",  imp_fail, '0);
        check("imp vacuous ffv",   64'(imp_ffv), '0);
        a = 4'h4; b = 4'h0; imp_ts = ts_m; tick();
        check("imp ch2 fail", imp_fail, c4(0,0,1,0));
        check("imp ch2 pass", imp_pass, '0);
        check("imp ffch",     64'(imp_ffch), 64'(2));
        check("imp ffts",     64'(imp_ffts), 64'(imp_ts));
        a = 4'h3; b = 4'h1; tick();
        check("imp pass",   imp_pass, c4(1,0,0,0));
        check("imp fail",   imp_fail, c4(0,1,1,0));
        check("imp total",  64'(imp_total), 64'(2));
        check("eq pass",    eq_pass, c4(4,3,4,5));
        check("eq fail",    eq_fail, c4(3,4,3,2));
        check("eq total",   64'(eq_total), 64'(12));
        check("eq ffch",    64'(eq_ffch), '0);
        check("eq ffts",    64'(eq_ffts), 64'(eq_ts));
        check("eq sticky",  64'(eq_sticky), 64'(4'hF));

        // Threshold alarm on ch0.
        en = 0; clr = 1; tick(); clr = 0;
        thresh = 16'd3; en = 1; mask = 4'h1; a = 4'h1; b = 4'h1;
        for (int i = 0; i < 3; i++) tick();
        check("thr armed alarm", 64'(and_alarm), '0);
        a = 4'h0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("thr total %0d", i), 64'(and_total), 64'(i));
            check($sformatf("thr alarm %0d", i), 64'(and_alarm), 64'(i == 3));
        end
        en = 0; tick(); tick();
        check("thr hold alarm", 64'(and_alarm), 64'(1));
        en = 1; tick();
        check("thr tripped count", and_fail, c4(4,0,0,0));
        check("thr tripped alarm", 64'(and_alarm), 64'(1));
        en = 0; clr = 1; tick(); clr = 0;
        check_and_zero("thr clr");
        thresh = '0;

        // Saturation: CNT_W=4 instance against the 16-bit one.
        en = 1; mask = 4'hF; a = 4'h0; b = 4'h0;
        for (int i = 0; i < 20; i++) tick();
        check("sat fail",    64'(sat_fail), 64'(16'hFFFF));
        check("sat total",   64'(sat_total), 64'(15));
        check("sat pass",    64'(sat_pass), '0);
        check("wide fail",   and_fail, c4(20,20,20,20));
        check("wide total",  64'(and_total), 64'(80));

        // A reset glitch between edges must not disturb state.
        en = 0;
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        check("glitch sat total", 64'(sat_total), 64'(15));
        check("glitch and total", 64'(and_total), 64'(80));

        // Mixed traffic, then a one-edge reset.
        en = 1; mask = 4'hF;
        for (int i = 0; i < 50; i++) begin
            a = 4'($urandom); b = 4'($urandom);
            tick();
        end
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        en = 0;
        check_and_zero("midreset");
        check("midreset sat fail", 64'(sat_fail), '0);
        en = 1; mask = 4'h1; a = 4'h0; b = 4'h0; tick();
        check("post reset ffv",  64'(and_ffv),  64'(1));
        check("post reset ffts", 64'(and_ffts), '0);
        check("post reset fail", and_fail, c4(1,0,0,0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
